ringbuf_readout_sched: RTL and testbench
========================================

// Module: ringbuf_readout_sched
// PURPOSE
//  Sequences the transfer of one triggered event from the per-channel sample FIFOs into the ring buffer.
//  Scan order: sample (outer), chip, channel (inner); one 12-bit word per cycle.
//  Drives chip/chan/sample indices, FIFO read strobe and ring-buffer write strobe.
//  Stalls at sample-block boundaries when the ring buffer lacks space; yields to JTAG readout.
// PARAMETERS
//  NCHIP  6   chips per event (CHIP counts 0..NCHIP-1)
//  NCHAN  16  channels per chip (CHAN counts 0..NCHAN-1)
//  BLK    96  words per sample block; must equal NCHIP*NCHAN
// PORTS
//  CLK        in   1   system clock; single clock domain
//  RST        in   1   synchronous, active-high reset
//  JTAG_MODE  in   1   1 = JTAG owns the FIFOs; scheduler idles or aborts
//  SAMP_MAX   in   7   last sample index; event = SAMP_MAX+1 samples
//  RDY        in   1   level; a complete event is present in the channel FIFOs
//  RB_FREE    in   12  free words in the ring buffer (saturating count, driven by buffer)
//  RE         out  1   FIFO read strobe for the word selected by CHIP/CHAN
//  CHIP       out  3   current chip index
//  CHAN       out  4   current channel index
//  SAMP       out  7   current sample index
//  WREN       out  1   ring-buffer write strobe; RE delayed 1 cycle (FIFO read latency 1)
//  SOE        out  1   1-cycle pulse coincident with first WREN of the event
//  EOE        out  1   1-cycle pulse coincident with last WREN of the event
//  BUSY       out  1   high in every state except IDLE
//  ABORT      out  1   1-cycle pulse when JTAG_MODE kills an event in progress
//  EVT_CNT    out  16  completed events; wraps 0xFFFF->0
// BEHAVIOUR
//  Reset (RST=1 at posedge): state=IDLE; all outputs 0; samp_max_l=0; delayed pipeline cleared.
//  States: IDLE, CHECK, XFER, DONE.
//  IDLE : if RDY & ~JTAG_MODE -> latch samp_max_l=SAMP_MAX, CHIP=CHAN=SAMP=0, go CHECK.
//  CHECK: if RB_FREE >= BLK -> XFER next cycle; else stay (no RE). Checked once per sample block.
//  XFER : RE=1 every cycle (combinational from state). After each cycle CHAN++;
//         CHAN==NCHAN-1 -> CHAN=0, CHIP++; CHIP==NCHIP-1 & CHAN==NCHAN-1 -> CHIP=0 and:
//         SAMP==samp_max_l -> DONE; else SAMP++, go CHECK.
//  DONE : one cycle, RE=0; EVT_CNT++; go IDLE. RDY still high in IDLE starts next event.
//  WREN/SOE/EOE: registered; WREN(t)=RE(t-1). SOE marks word (0,0,0), EOE marks word
//    (samp_max_l, NCHIP-1, NCHAN-1); with samp_max_l=0 both are distinct cycles 95 apart.
//  Latency: RDY seen in IDLE at cycle 0 -> CHECK cycle 1 -> first RE cycle 2 (space ok) -> first WREN cycle 3.
//  Words per event = BLK*(samp_max_l+1); max 12288. SAMP_MAX changes mid-event ignored.
//  Space rule: BLK words guaranteed before each block; RB_FREE not sampled within XFER.
//  JTAG_MODE=1 in CHECK/XFER/DONE: next state IDLE, RE forced 0 same cycle, indices cleared,
//    ABORT pulse (not in DONE: event counts as complete). Pending WREN of last RE still issues.
//  JTAG_MODE=1 in IDLE: stay IDLE, no ABORT. RDY dropping mid-event: ignored (event committed).
//  RST mid-event: immediate return to IDLE, no ABORT, EVT_CNT=0, pending WREN discarded.
//  RE/WREN never asserted while JTAG_MODE=1 is observed in the same cycle (except WREN of prior RE).
// TESTING
//  1 RST, RDY=1, SAMP_MAX=0, RB_FREE=4095 -> first RE cycle 2, 96 RE, 96 WREN, SOE/EOE once, EVT_CNT=1.
//  2 SAMP_MAX=7, RB_FREE=4095 -> 768 words, SAMP 0..7, CHECK gap 1 cycle between blocks, order chan-inner.
//  3 SAMP_MAX=2, RB_FREE=95 after block 0 for 20 cycles then 200 -> CHECK holds 20 cycles, no RE, then resumes.
//  4 JTAG_MODE=1 at word 50 of sample 1 -> RE=0 same cycle, ABORT pulse, BUSY=0 next, EVT_CNT unchanged.
//  5 RDY held high, SAMP_MAX=0, 3 events -> back-to-back events, EVT_CNT=3, SOE/EOE 3 each.
//  6 EVT_CNT preloaded by 65535 events (or force) + 1 event -> wraps to 0; RST mid-XFER -> all outputs 0 next cycle.

Source files
------------

// File: rtl/ringbuf_readout_sched.sv
`default_nettype none
// ============================================================================
// Module : ringbuf_readout_sched
// Brief  : Moves one triggered event from the channel FIFOs into the ring
//          buffer, one word per cycle, in sample/chip/channel order.
// Rev    : 1.0  initial release
// ============================================================================
module ringbuf_readout_sched #(
  parameter int NCHIP = 6,
  parameter int NCHAN = 16,
  parameter int BLK   = 96
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        JTAG_MODE,
  input  logic [6:0]  SAMP_MAX,
  input  logic        RDY,
  input  logic [11:0] RB_FREE,
  output logic        RE,
  output logic [2:0]  CHIP,
  output logic [3:0]  CHAN,
  output logic [6:0]  SAMP,
  output logic        WREN,
  output logic        SOE,
  output logic        EOE,
  output logic        BUSY,
  output logic        ABORT,
  output logic [15:0] EVT_CNT
);

  localparam logic [2:0]  c_chip_last = 3'(NCHIP - 1);
  localparam logic [3:0]  c_chan_last = 4'(NCHAN - 1);
  localparam logic [11:0] c_blk       = 12'(BLK);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    XFER  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t      r_state;
  logic [2:0]  r_chip;
  logic [3:0]  r_chan;
  logic [6:0]  r_samp;
  logic [6:0]  r_samp_max_l;
  logic        r_wren;
  logic        r_soe;
  logic        r_eoe;
  logic        r_abort;
  logic [15:0] r_evt_cnt;

  logic w_re;
  logic w_last_word;

  // JTAG takeover must silence the FIFO read in the very cycle it is seen.
  assign w_re        = (r_state == XFER) && !JTAG_MODE;
  assign w_last_word = (r_chip == c_chip_last) && (r_chan == c_chan_last);

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state      <= IDLE;
      r_chip       <= 3'd0;
      r_chan       <= 4'd0;
      r_samp       <= 7'd0;
      r_samp_max_l <= 7'd0;
      r_wren       <= 1'b0;
      r_soe        <= 1'b0;
      r_eoe        <= 1'b0;
      r_abort      <= 1'b0;
      r_evt_cnt    <= 16'd0;
    end else begin
      // Write side trails the read strobe by the FIFO read latency.
      r_wren  <= w_re;
      r_soe   <= w_re && (r_samp == 7'd0) && (r_chip == 3'd0) && (r_chan == 4'd0);
      r_eoe   <= w_re && w_last_word && (r_samp == r_samp_max_l);
      r_abort <= 1'b0;

      case (r_state)
        IDLE: begin
          if (RDY && !JTAG_MODE) begin
            r_samp_max_l <= SAMP_MAX;
            r_chip       <= 3'd0;
            r_chan       <= 4'd0;
            r_samp       <= 7'd0;
            r_state      <= CHECK;
          end
        end

        CHECK: begin
          if (JTAG_MODE) begin
            r_state <= IDLE;
            r_chip  <= 3'd0;
            r_chan  <= 4'd0;
            r_samp  <= 7'd0;
            r_abort <= 1'b1;
          end else if (RB_FREE >= c_blk) begin
            r_state <= XFER;
          end
        end

        XFER: begin
          if (JTAG_MODE) begin
            r_state <= IDLE;
            r_chip  <= 3'd0;
            r_chan  <= 4'd0;
            r_samp  <= 7'd0;
            r_abort <= 1'b1;
          end else if (w_last_word) begin
            r_chip <= 3'd0;
            r_chan <= 4'd0;
            if (r_samp == r_samp_max_l) begin
              r_state <= DONE;
            end else begin
              r_samp  <= r_samp + 7'd1;
              r_state <= CHECK;
            end
          end else if (r_chan == c_chan_last) begin
            r_chan <= 4'd0;
            r_chip <= r_chip + 3'd1;
          end else begin
            r_chan <= r_chan + 4'd1;
          end
        end

        DONE: begin
          // All words were already read, so a late JTAG request still counts it.
          r_evt_cnt <= r_evt_cnt + 16'd1;
          r_chip    <= 3'd0;
          r_chan    <= 4'd0;
          r_samp    <= 7'd0;
          r_state   <= IDLE;
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  assign RE      = w_re;
  assign CHIP    = r_chip;
  assign CHAN    = r_chan;
  assign SAMP    = r_samp;
  assign WREN    = r_wren;
  assign SOE     = r_soe;
  assign EOE     = r_eoe;
  assign BUSY    = (r_state != IDLE);
  assign ABORT   = r_abort;
  assign EVT_CNT = r_evt_cnt;

endmodule
`default_nettype wire

// File: tb/tb_ringbuf_readout_sched.sv
`default_nettype none
// ============================================================================
// Module : tb_ringbuf_readout_sched
// Brief  : Scoreboard bench for ringbuf_readout_sched.
// Rev    : 1.0  initial release
// ============================================================================
module tb_ringbuf_readout_sched;

  logic        CLK = 1'b0;
  logic        RST;
  logic        JTAG_MODE;
  logic [6:0]  SAMP_MAX;
  logic        RDY;
  logic [11:0] RB_FREE;
  logic        RE;
  logic [2:0]  CHIP;
  logic [3:0]  CHAN;
  logic [6:0]  SAMP;
  logic        WREN;
  logic        SOE;
  logic        EOE;
  logic        BUSY;
  logic        ABORT;
  logic [15:0] EVT_CNT;

  ringbuf_readout_sched #(.NCHIP(6), .NCHAN(16), .BLK(96)) dut (
    .CLK(CLK), .RST(RST), .JTAG_MODE(JTAG_MODE), .SAMP_MAX(SAMP_MAX),
    .RDY(RDY), .RB_FREE(RB_FREE), .RE(RE), .CHIP(CHIP), .CHAN(CHAN),
    .SAMP(SAMP), .WREN(WREN), .SOE(SOE), .EOE(EOE), .BUSY(BUSY),
    .ABORT(ABORT), .EVT_CNT(EVT_CNT)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [6:0] samp;
    logic [2:0] chip;
    logic [3:0] chan;
    logic       soe;
    logic       eoe;
  } word_t;

  word_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int re_cnt = 0, wren_cnt = 0, soe_cnt = 0, eoe_cnt = 0;
  logic [6:0] prev_samp = '0;
  logic [2:0] prev_chip = '0;
  logic [3:0] prev_chan = '0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Expected write stream for the first n words of an event of smax+1 samples.
  task automatic push_words(input int smax, input int n);
    int k = 0;
    for (int s = 0; s <= smax; s++)
      for (int c = 0; c < 6; c++)
        for (int h = 0; h < 16; h++) begin
          if (k < n)
            exp_q.push_back('{samp: 7'(s), chip: 3'(c), chan: 4'(h),
                              soe: (k == 0),
                              eoe: (s == smax && c == 5 && h == 15)});
          k++;
        end
  endtask

  task automatic wait_re(input string name, output int lat);
    lat = 0;
    do begin
      step();
      lat++;
    end while (!RE && lat < 300);
    if (!RE) chk(name, 0, 1);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (BUSY && n < 20000) begin
      step();
      n++;
    end
    chk(name, int'(BUSY), 0);
    chk({name, "_queue_left"}, exp_q.size(), 0);
  endtask

  // Monitor: every write pops the word whose read strobe preceded it.
  always @(negedge CLK) begin
    word_t e;
    word_t a;
    if (WREN) begin
      wren_cnt++;
      checks++;
      a = '{samp: prev_samp, chip: prev_chip, chan: prev_chan, soe: SOE, eoe: EOE};
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL wren_extra actual=%h required=none", a);
      end else begin
        e = exp_q.pop_front();
        if (a !== e) begin
          errors++;
          $display("FAIL word actual=s%0d c%0d h%0d soe%0b eoe%0b required=s%0d c%0d h%0d soe%0b eoe%0b",
                   a.samp, a.chip, a.chan, a.soe, a.eoe, e.samp, e.chip, e.chan, e.soe, e.eoe);
        end
      end
    end else if (SOE || EOE) begin
      checks++;
      errors++;
      $display("FAIL marker_without_wren actual=soe%0b eoe%0b required=00", SOE, EOE);
    end
    if (RE && JTAG_MODE) begin
      checks++;
      errors++;
      $display("FAIL re_during_jtag actual=1 required=0");
    end
    if (RE) begin
      re_cnt++;
      prev_samp = SAMP;
      prev_chip = CHIP;
      prev_chan = CHAN;
    end
    soe_cnt += int'(SOE);
    eoe_cnt += int'(EOE);
  end

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, span, hold_re, hold_busy, soe0, eoe0, n;
    int exp_evt = 0;

    // Test 1: reset state, single-sample event, latency
    RST = 1'b1; JTAG_MODE = 1'b0; SAMP_MAX = 7'd0; RDY = 1'b1; RB_FREE = 12'd4095;
    repeat (3) step();
    chk("reset_ctl", int'({RE, WREN, SOE, EOE, BUSY, ABORT, CHIP, CHAN, SAMP}), 0);
    chk("reset_evt", int'(EVT_CNT), 0);
    push_words(0, 96);
    RST = 1'b0;
    wait_re("t1_first_re", lat);
    chk("t1_latency", lat, 2);
    RDY = 1'b0;
    wait_idle("t1_idle");
    exp_evt = 1;
    chk("t1_evt_cnt", int'(EVT_CNT), exp_evt);
    chk("t1_re_cnt", re_cnt, 96);
    chk("t1_wren_cnt", wren_cnt, 96);
    chk("t1_soe_cnt", soe_cnt, 1);
    chk("t1_eoe_cnt", eoe_cnt, 1);

    // Test 2: eight samples, one CHECK cycle between blocks, SAMP_MAX ignored mid-event
    SAMP_MAX = 7'd7;
    push_words(7, 768);
    RDY = 1'b1;
    wait_re("t2_first_re", lat);
    RDY = 1'b0;
    SAMP_MAX = 7'd0;
    span = 0;
    while (!EOE && span < 2000) begin
      step();
      span++;
    end
    chk("t2_span", span, 775);
    wait_idle("t2_idle");
    exp_evt++;
    chk("t2_evt_cnt", int'(EVT_CNT), exp_evt);

    // Test 3: ring buffer short of space before block 1
    SAMP_MAX = 7'd2;
    push_words(2, 288);
    RDY = 1'b1;
    wait_re("t3_first_re", lat);
    RDY = 1'b0;
    RB_FREE = 12'd95;
    repeat (96) step();
    hold_re = 0; hold_busy = 1;
    for (int i = 0; i < 20; i++) begin
      hold_re += int'(RE);
      hold_busy &= int'(BUSY);
      if (i < 19) step();
    end
    chk("t3_hold_re", hold_re, 0);
    chk("t3_hold_busy", hold_busy, 1);
    RB_FREE = 12'd200;
    step();
    chk("t3_resume_re", int'(RE), 1);
    chk("t3_resume_samp", int'(SAMP), 1);
    wait_idle("t3_idle");
    RB_FREE = 12'd4095;
    exp_evt++;
    chk("t3_evt_cnt", int'(EVT_CNT), exp_evt);

    // Test 4: JTAG takeover at word 50 of sample 1
    push_words(2, 146);
    RDY = 1'b1;
    wait_re("t4_first_re", lat);
    RDY = 1'b0;
    repeat (147) step();
    chk("t4_word_chip", int'(CHIP), 3);
    chk("t4_word_chan", int'(CHAN), 2);
    chk("t4_word_samp", int'(SAMP), 1);
    JTAG_MODE = 1'b1;
    #1;
    chk("t4_re_killed", int'(RE), 0);
    step();
    chk("t4_abort", int'(ABORT), 1);
    chk("t4_busy", int'(BUSY), 0);
    chk("t4_idx", int'({CHIP, CHAN, SAMP}), 0);
    step();
    chk("t4_abort_pulse", int'(ABORT), 0);
    chk("t4_evt_cnt", int'(EVT_CNT), exp_evt);
    chk("t4_queue_left", exp_q.size(), 0);
    RDY = 1'b1;
    repeat (3) step();
    chk("t4_jtag_idle_busy", int'(BUSY), 0);
    chk("t4_jtag_idle_abort", int'(ABORT), 0);
    RDY = 1'b0;
    JTAG_MODE = 1'b0;
    step();

    // Test 5: three back-to-back events with RDY held
    SAMP_MAX = 7'd0;
    soe0 = soe_cnt; eoe0 = eoe_cnt;
    push_words(0, 96); push_words(0, 96); push_words(0, 96);
    RDY = 1'b1;
    n = 0;
    while (!(RE && EVT_CNT == 16'(exp_evt + 2)) && n < 2000) begin
      step();
      n++;
    end
    RDY = 1'b0;
    wait_idle("t5_idle");
    exp_evt += 3;
    chk("t5_evt_cnt", int'(EVT_CNT), exp_evt);
    chk("t5_soe_cnt", soe_cnt - soe0, 3);
    chk("t5_eoe_cnt", eoe_cnt - eoe0, 3);

    // Test 6: counter wrap, then reset mid-transfer
    force dut.r_evt_cnt = 16'hFFFF;
    step();
    release dut.r_evt_cnt;
    step();
    chk("t6_preload", int'(EVT_CNT), 65535);
    push_words(0, 96);
    RDY = 1'b1;
    wait_re("t6_first_re", lat);
    RDY = 1'b0;
    wait_idle("t6_idle");
    chk("t6_wrap", int'(EVT_CNT), 0);

    push_words(0, 9);
    RDY = 1'b1;
    wait_re("t6r_first_re", lat);
    RDY = 1'b0;
    repeat (9) step();
    RST = 1'b1;
    step();
    chk("t6_rst_ctl", int'({RE, WREN, SOE, EOE, BUSY, ABORT, CHIP, CHAN, SAMP}), 0);
    chk("t6_rst_evt", int'(EVT_CNT), 0);
    RST = 1'b0;
    repeat (3) step();
    chk("t6_rst_queue", exp_q.size(), 0);
    chk("t6_rst_busy", int'(BUSY), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
